// File: rtl/data_path.sv
// Multicycle MIPS-subset datapath: 32x32 register file, ALU and a memory-handshake controller.
// Every output is registered; fetch and load/store waits hold MOV until MOC/DMOC is sampled.
module data_path (
  output logic [31:0] IR,
  output logic [31:0] MAR,
  output logic [31:0] PC,
  output logic [31:0] nPC,
  output logic [31:0] DataIn,
  output logic [31:0] regFileA_o,
  output logic [31:0] regFileB_o,
  output logic        RW,
  output logic        MOV,
  output logic        RF,
  output logic [6:0]  aState,
  output logic [5:0]  OpC,
  output logic [4:0]  MA_o,
  output logic [4:0]  B_o,
  input  logic        clk,
  input  logic        reset,
  input  logic        Cond,
  input  logic        MOC,
  input  logic        DMOC,
  input  logic [31:0] DataOut
);

  typedef enum logic [6:0] {
    S_RESET      = 7'd0,
    S_FETCH      = 7'd1,
    S_FETCH_WAIT = 7'd2,
    S_DECODE     = 7'd3,
    S_EXEC       = 7'd4,
    S_WRITEBACK  = 7'd5,
    S_MEM_ADDR   = 7'd6,
    S_LOAD_WAIT  = 7'd7,
    S_STORE_WAIT = 7'd8,
    S_BRANCH     = 7'd9,
    S_JUMP       = 7'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  state_e      state_q;
  logic [31:0] ir_q, mar_q, pc_q, npc_q, din_q, result_q;
  logic        rw_q, mov_q, rf_q;
  logic [5:0]  opc_q;
  logic [4:0]  dest_q;
  logic [31:0] regs_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] sext_imm, rs_val, rt_val, alu_d, load_d;
  logic        alu_ok, br_taken;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regs_q[rt];
  assign br_taken = (op == OP_BEQ) ? (rs_val == rt_val) : (rs_val != rt_val);
  // Memory returns data right-aligned, so a byte load only needs sign extension here.
  assign load_d   = (op == OP_LB) ? {{24{DataOut[7]}}, DataOut[7:0]} : DataOut;

  always_comb begin
    alu_d  = 32'd0;
    alu_ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        alu_ok = 1'b1;
        case (funct)
          FN_ADDU: alu_d = rs_val + rt_val;
          FN_SUBU: alu_d = rs_val - rt_val;
          FN_AND:  alu_d = rs_val & rt_val;
          FN_OR:   alu_d = rs_val | rt_val;
          FN_SLT:  alu_d = {31'd0, $signed(rs_val) < $signed(rt_val)};
          default: alu_ok = 1'b0;
        endcase
      end
      OP_ADDIU: begin alu_ok = 1'b1; alu_d = rs_val + sext_imm; end
      OP_ORI:   begin alu_ok = 1'b1; alu_d = rs_val | {16'd0, imm}; end
      OP_LUI:   begin alu_ok = 1'b1; alu_d = {imm, 16'd0}; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RESET;
      pc_q     <= 32'd0;
      npc_q    <= 32'd4;
      ir_q     <= 32'd0;
      mar_q    <= 32'd0;
      din_q    <= 32'd0;
      result_q <= 32'd0;
      dest_q   <= 5'd0;
      rw_q     <= 1'b1;
      mov_q    <= 1'b0;
      rf_q     <= 1'b0;
      opc_q    <= 6'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      case (state_q)
        // Leaving reset issues the first fetch so MOV is already up in FETCH.
        S_RESET, S_FETCH: begin
          mar_q   <= pc_q;
          mov_q   <= 1'b1;
          rw_q    <= 1'b1;
          rf_q    <= 1'b0;
          opc_q   <= OP_LW;
          state_q <= (state_q == S_RESET) ? S_FETCH : S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          if (MOC) begin
            ir_q    <= DataOut;
            pc_q    <= npc_q;
            npc_q   <= npc_q + 32'd4;
            mov_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (op)
            OP_RTYPE, OP_ADDIU, OP_ORI, OP_LUI: state_q <= alu_ok ? S_EXEC : S_FETCH;
            OP_LW, OP_LB, OP_SW, OP_SB:         state_q <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:                     state_q <= S_BRANCH;
            OP_J:                               state_q <= S_JUMP;
            default:                            state_q <= S_FETCH;
          endcase
        end
        S_EXEC: begin
          result_q <= alu_d;
          dest_q   <= (op == OP_RTYPE) ? rd : rt;
          rf_q     <= 1'b1;
          state_q  <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (dest_q != 5'd0) regs_q[dest_q] <= result_q;
          rf_q    <= 1'b0;
          state_q <= S_FETCH;
        end
        S_MEM_ADDR: begin
          mar_q <= rs_val + sext_imm;
          opc_q <= op;
          mov_q <= 1'b1;
          if (op == OP_LW || op == OP_LB) begin
            rw_q    <= 1'b1;
            state_q <= S_LOAD_WAIT;
          end else begin
            rw_q    <= 1'b0;
            din_q   <= rt_val;
            state_q <= S_STORE_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          if (DMOC) begin
            if (rt != 5'd0) regs_q[rt] <= load_d;
            rf_q    <= 1'b1;
            mov_q   <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_STORE_WAIT: begin
          if (DMOC) begin
            mov_q   <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_BRANCH: begin
          // pc_q already points at the delay slot, so the offset is relative to it.
          if (br_taken) npc_q <= pc_q + {sext_imm[29:0], 2'b00};
          state_q <= S_FETCH;
        end
        S_JUMP: begin
          npc_q   <= {pc_q[31:28], ir_q[25:0], 2'b00};
          state_q <= S_FETCH;
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{Cond, ir_q[10:6]};

  assign IR         = ir_q;
  assign MAR        = mar_q;
  assign PC         = pc_q;
  assign nPC        = npc_q;
  assign DataIn     = din_q;
  assign regFileA_o = rs_val;
  assign regFileB_o = rt_val;
  assign RW         = rw_q;
  assign MOV        = mov_q;
  assign RF         = rf_q;
  assign aState     = state_q;
  assign OpC        = opc_q;
  assign MA_o       = rs;
  assign B_o        = rt;

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: behavioural 512-byte memory responder plus a probe-instruction scoreboard.
module tb_data_path;

  logic [31:0] IR, MAR, PC, nPC, DataIn, regFileA_o, regFileB_o;
  logic        RW, MOV, RF;
  logic [6:0]  aState;
  logic [5:0]  OpC;
  logic [4:0]  MA_o, B_o;
  logic        clk, reset, Cond, MOC, DMOC;
  logic [31:0] DataOut;

  data_path dut (
    .IR(IR), .MAR(MAR), .PC(PC), .nPC(nPC), .DataIn(DataIn),
    .regFileA_o(regFileA_o), .regFileB_o(regFileB_o),
    .RW(RW), .MOV(MOV), .RF(RF), .aState(aState), .OpC(OpC),
    .MA_o(MA_o), .B_o(B_o), .clk(clk), .reset(reset), .Cond(Cond),
    .MOC(MOC), .DMOC(DMOC), .DataOut(DataOut)
  );

  localparam logic [5:0] ADDIU = 6'b001001, ORI = 6'b001101, LUI = 6'b001111;
  localparam logic [5:0] LB = 6'b100000, LW = 6'b100011, BNE = 6'b000101;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  logic [31:0] mem [128];
  logic [31:0] exp_q [$];
  int tests_run = 0;
  int tests_failed = 0;
  int moc_delay = 0;
  int dmoc_delay = 0;
  int wait_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  // Opcode 111111 decodes back to FETCH as a NOP, exposing register r on regFileA_o in DECODE.
  function automatic logic [31:0] probe(input logic [4:0] r);
    return {6'b111111, r, r, 16'h0000};
  endfunction

  // Memory responder: answers fetches, loads and stores after a programmable number of cycles.
  initial begin
    logic [31:0] w;
    int sh;
    MOC = 1'b0; DMOC = 1'b0; DataOut = 32'd0; Cond = 1'b0;
    forever begin
      @(negedge clk);
      Cond = 1'($urandom_range(0, 1));
      MOC = 1'b0;
      DMOC = 1'b0;
      if (!reset && MOV && (aState == 7'd2 || aState == 7'd7 || aState == 7'd8)) begin
        if (wait_cnt < ((aState == 7'd2) ? moc_delay : dmoc_delay)) begin
          wait_cnt++;
        end else if (aState == 7'd2) begin
          MOC = 1'b1;
          DataOut = mem[MAR[8:2]];
        end else if (aState == 7'd7) begin
          DMOC = 1'b1;
          w = mem[MAR[8:2]];
          sh = 8 * (3 - int'(MAR[1:0]));
          DataOut = (OpC == LB) ? ((w >> sh) & 32'hFF) : w;
        end else begin
          DMOC = 1'b1;
          mem[MAR[8:2]] = DataIn;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: each probe reaching DECODE pops the next expected register value.
  initial begin
    logic [31:0] exp;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && aState == 7'd3 && IR[31:26] == 6'b111111) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL probe_unexpected r%0d: got %h, required no probe", MA_o, regFileA_o);
        end else begin
          exp = exp_q.pop_front();
          if (regFileA_o !== exp) begin
            tests_failed++;
            $display("FAIL probe r%0d: got %h, required %h", MA_o, regFileA_o, exp);
          end
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [6:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (aState == s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_to_pc(input logic [31:0] stop_pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (aState == 7'd1 && PC == stop_pc) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({aState, PC, nPC, IR, MAR, DataIn} !== {7'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL reset_regs: got %h, required %h", {aState, PC, nPC, IR, MAR, DataIn}, {7'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0});
    end
    tests_run++;
    if ({RW, MOV, RF, OpC} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required %b", {RW, MOV, RF, OpC}, {1'b1, 1'b0, 1'b0, 6'd0});
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({aState, MOV, RW, MAR, OpC} !== {7'd1, 1'b1, 1'b1, 32'd0, LW}) begin
      tests_failed++;
      $display("FAIL first_fetch: got %h, required %h", {aState, MOV, RW, MAR, OpC}, {7'd1, 1'b1, 1'b1, 32'd0, LW});
    end
  endtask

  task automatic test_addiu();
    bit ok;
    clear_mem();
    mem[0] = 32'h24010005;
    mem[1] = probe(5'd1);
    exp_q.push_back(32'd5);
    do_reset();
    wait_state(7'd3, ok);
    tests_run++;
    if (!ok || {IR, PC, nPC} !== {32'h24010005, 32'd4, 32'd8}) begin
      tests_failed++;
      $display("FAIL addiu_fetch: got %h, required %h", {IR, PC, nPC}, {32'h24010005, 32'd4, 32'd8});
    end
    wait_state(7'd5, ok);
    tests_run++;
    if (!ok || RF !== 1'b1) begin
      tests_failed++;
      $display("FAIL addiu_rf_pulse: got %b, required 1", RF);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({aState, RF} !== {7'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL addiu_rf_drop: got %h, required %h", {aState, RF}, {7'd1, 1'b0});
    end
    run_to_pc(32'd8, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL addiu_done: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_load();
    bit ok;
    clear_mem();
    mem[0] = 32'h8C020100;
    mem[1] = enc_i(LB, 5'd0, 5'd3, 16'h0101);
    mem[2] = probe(5'd2);
    mem[3] = probe(5'd3);
    mem[64] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hFFFFFFAD);
    dmoc_delay = 2;
    do_reset();
    wait_state(7'd7, ok);
    tests_run++;
    if (!ok || {MAR, OpC, MOV, RW} !== {32'h100, LW, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL lw_request: got %h, required %h", {MAR, OpC, MOV, RW}, {32'h100, LW, 1'b1, 1'b1});
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({aState, MOV} !== {7'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL lw_hold: got %h, required %h", {aState, MOV}, {7'd7, 1'b1});
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({aState, RF, MOV} !== {7'd1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL lw_complete: got %h, required %h", {aState, RF, MOV}, {7'd1, 1'b1, 1'b0});
    end
    wait_state(7'd7, ok);
    tests_run++;
    if (!ok || {MAR, OpC} !== {32'h101, LB}) begin
      tests_failed++;
      $display("FAIL lb_request: got %h, required %h", {MAR, OpC}, {32'h101, LB});
    end
    run_to_pc(32'h10, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL load_done: got %0d pending, required 0", exp_q.size());
    end
    dmoc_delay = 0;
  endtask

  task automatic test_store();
    bit ok;
    clear_mem();
    mem[0] = 32'h24010005;
    mem[1] = 32'hAC010104;
    mem[2] = enc_i(LW, 5'd0, 5'd4, 16'h0104);
    mem[3] = probe(5'd4);
    exp_q.push_back(32'd5);
    do_reset();
    wait_state(7'd8, ok);
    tests_run++;
    if (!ok || {MOV, RW, MAR, DataIn, OpC} !== {1'b1, 1'b0, 32'h104, 32'd5, 6'b101011}) begin
      tests_failed++;
      $display("FAIL sw_request: got %h, required %h", {MOV, RW, MAR, DataIn, OpC}, {1'b1, 1'b0, 32'h104, 32'd5, 6'b101011});
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({aState, MOV} !== {7'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL sw_mov_drop: got %h, required %h", {aState, MOV}, {7'd1, 1'b0});
    end
    run_to_pc(32'h10, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0 || mem[65] !== 32'd5) begin
      tests_failed++;
      $display("FAIL store_done: got pending %0d mem %h, required 0 and 00000005", exp_q.size(), mem[65]);
    end
  endtask

  task automatic test_alu();
    bit ok;
    logic [31:0] alu_exp [9];
    alu_exp = '{32'd4, 32'hFFFFFFF6, 32'd5, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h00008007, 32'hABCD0000, 32'd0};
    clear_mem();
    mem[0]  = enc_i(ADDIU, 5'd0, 5'd1, 16'hFFFD);
    mem[1]  = enc_i(ADDIU, 5'd0, 5'd2, 16'h0007);
    mem[2]  = enc_r(5'd1, 5'd2, 5'd3, F_ADDU);
    mem[3]  = enc_r(5'd1, 5'd2, 5'd4, F_SUBU);
    mem[4]  = enc_r(5'd1, 5'd2, 5'd5, F_AND);
    mem[5]  = enc_r(5'd1, 5'd2, 5'd6, F_OR);
    mem[6]  = enc_r(5'd1, 5'd2, 5'd7, F_SLT);
    mem[7]  = enc_r(5'd2, 5'd1, 5'd8, F_SLT);
    mem[8]  = enc_i(ORI, 5'd2, 5'd9, 16'h8000);
    mem[9]  = enc_i(LUI, 5'd0, 5'd10, 16'hABCD);
    mem[10] = enc_i(ADDIU, 5'd6, 5'd11, 16'h0001);
    for (int i = 0; i < 9; i++) begin
      mem[11 + i] = probe(5'(3 + i));
      exp_q.push_back(alu_exp[i]);
    end
    do_reset();
    run_to_pc(32'h50, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL alu_done: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_r0_and_wait();
    bit ok;
    bit held;
    clear_mem();
    mem[0] = 32'h24000007;
    mem[1] = probe(5'd0);
    exp_q.push_back(32'd0);
    moc_delay = 5;
    do_reset();
    wait_state(7'd2, ok);
    held = ok;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (aState !== 7'd2 || MOV !== 1'b1) held = 1'b0;
    end
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL fetch_wait_hold: got state %0d mov %b, required 2 and 1", aState, MOV);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({aState, IR} !== {7'd3, 32'h24000007}) begin
      tests_failed++;
      $display("FAIL fetch_after_wait: got %h, required %h", {aState, IR}, {7'd3, 32'h24000007});
    end
    run_to_pc(32'd8, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL r0_done: got %0d pending, required 0", exp_q.size());
    end
    moc_delay = 0;
  endtask

  task automatic test_branch_jump();
    bit ok;
    clear_mem();
    mem[0]  = 32'h10000003;
    mem[1]  = enc_i(ADDIU, 5'd0, 5'd1, 16'd9);
    mem[2]  = enc_i(ADDIU, 5'd0, 5'd2, 16'd1);
    mem[4]  = probe(5'd1);
    mem[5]  = probe(5'd2);
    mem[6]  = enc_i(BNE, 5'd1, 5'd1, 16'd5);
    mem[7]  = probe(5'd1);
    mem[8]  = probe(5'd2);
    mem[9]  = 32'h08000010;
    mem[10] = probe(5'd1);
    mem[16] = probe(5'd2);
    exp_q.push_back(32'd9); exp_q.push_back(32'd0);
    exp_q.push_back(32'd9); exp_q.push_back(32'd0);
    exp_q.push_back(32'd9); exp_q.push_back(32'd0);
    do_reset();
    wait_state(7'd9, ok);
    @(posedge clk);
    #1;
    tests_run++;
    if (!ok || {aState, PC, nPC} !== {7'd1, 32'd4, 32'd16}) begin
      tests_failed++;
      $display("FAIL beq_taken: got %h, required %h", {aState, PC, nPC}, {7'd1, 32'd4, 32'd16});
    end
    wait_state(7'd3, ok);
    tests_run++;
    if (!ok || {IR, PC, nPC} !== {32'h24010009, 32'd16, 32'd20}) begin
      tests_failed++;
      $display("FAIL delay_slot: got %h, required %h", {IR, PC, nPC}, {32'h24010009, 32'd16, 32'd20});
    end
    wait_state(7'd9, ok);
    @(posedge clk);
    #1;
    tests_run++;
    if (!ok || {aState, PC, nPC} !== {7'd1, 32'h1C, 32'h20}) begin
      tests_failed++;
      $display("FAIL bne_not_taken: got %h, required %h", {aState, PC, nPC}, {7'd1, 32'h1C, 32'h20});
    end
    wait_state(7'd10, ok);
    @(posedge clk);
    #1;
    tests_run++;
    if (!ok || {aState, PC, nPC} !== {7'd1, 32'h28, 32'h40}) begin
      tests_failed++;
      $display("FAIL jump: got %h, required %h", {aState, PC, nPC}, {7'd1, 32'h28, 32'h40});
    end
    run_to_pc(32'h44, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL branch_done: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midwait();
    bit ok;
    clear_mem();
    mem[0] = probe(5'd5);
    mem[1] = enc_i(LW, 5'd0, 5'd5, 16'h0100);
    mem[64] = 32'h12345678;
    wait_state(7'd2, ok);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (!ok || {aState, PC, nPC, IR, MAR, MOV} !== {7'd0, 32'd0, 32'd4, 32'd0, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_in_fetch_wait: got %h, required %h", {aState, PC, nPC, IR, MAR, MOV}, {7'd0, 32'd0, 32'd4, 32'd0, 32'd0, 1'b0});
    end
    tests_run++;
    if ({DataIn, OpC, RW, RF} !== {32'd0, 6'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, required %h", {DataIn, OpC, RW, RF}, {32'd0, 6'd0, 1'b1, 1'b0});
    end
    exp_q.push_back(32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_state(7'd7, ok);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (!ok || {aState, MOV, RF} !== {7'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_in_load_wait: got %h, required %h", {aState, MOV, RF}, {7'd0, 1'b0, 1'b0});
    end
    exp_q.push_back(32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_to_pc(32'd4, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midwait_done: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_mem();
    test_reset();
    test_addiu();
    test_load();
    test_store();
    test_alu();
    test_r0_and_wait();
    test_branch_jump();
    test_reset_midwait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
